// File: rtl/eeprom_iic_pkg.sv
// Shared types and constants for the I2C EEPROM target.
// Holds the FSM state encoding and the default device select code.
`timescale 1ns/1ps
package eeprom_iic_pkg;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h50;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        ADDR,
        ADDR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        WAIT_STOP
    } state_e;

endpackage

// File: rtl/iic_bus_cond_det.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection.
// Bit [1] of each shift is the synchronized level, bit [2] its previous value.
`timescale 1ns/1ps
module iic_bus_cond_det (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign sda      = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/eeprom_iic_tgt.sv
// I2C target front-end for a 24Cxx-style EEPROM byte array.
// Handles device select, address bytes, page writes and sequential reads.
`timescale 1ns/1ps
module eeprom_iic_tgt
    import eeprom_iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR      = DEF_DEV_ADDR,
    parameter int         ADDR_WIDTH    = 12,
    parameter int         PAGE_SIZE     = 32,
    parameter int         REG_ADDR_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iic_scl,
    input  logic                  iic_sda_in,
    output logic                  iic_sda_out,
    output logic                  iic_sda_out_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [7:0]            mem_wr_data,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_rd_data,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_SIZE - 1);
    localparam logic [1:0]            RA_LAST   = 2'(REG_ADDR_SIZE);

    logic sda, scl_rise, scl_fall, start, stop;

    iic_bus_cond_det u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (iic_scl),
        .sda_in   (iic_sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]            addr_cnt_q, addr_cnt_d;
    logic [7:0]            sh_q, sh_d;
    logic                  rw_q, rw_d;
    logic [7:0]            rd_byte_q, rd_byte_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  sda_out_q, sda_out_d;
    logic                  sda_en_q, sda_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [7:0]            mem_wr_data_q, mem_wr_data_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        addr_cnt_d    = addr_cnt_q;
        sh_d          = sh_q;
        rw_d          = rw_q;
        sda_out_d     = sda_out_q;
        sda_en_d      = sda_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_en_d   = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        mem_rd_en_d   = 1'b0;
        busy_d        = busy_q;
        // read data arrives one clk after the strobe
        rd_pend_d     = mem_rd_en_q;
        rd_byte_d     = rd_pend_q ? mem_rd_data : rd_byte_q;

        if (stop) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
            sda_en_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = DEV;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
            sda_en_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, WAIT_STOP: begin
                end
                DEV, ADDR, WR: begin
                    if (scl_rise) begin
                        sh_d      = {sh_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_out_d = 1'b0;
                        sda_en_d  = 1'b1;
                        if (state_q == DEV) begin
                            if (sh_q[7:1] == DEV_ADDR) begin
                                state_d = DEV_ACK;
                                rw_d    = sh_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d   = WAIT_STOP;
                                sda_out_d = 1'b1;
                                sda_en_d  = 1'b0;
                                busy_d    = 1'b0;
                            end
                        end else if (state_q == ADDR) begin
                            state_d    = ADDR_ACK;
                            mem_addr_d = ADDR_WIDTH'({mem_addr_q, sh_q});
                            addr_cnt_d = addr_cnt_q + 2'd1;
                        end else begin
                            state_d       = WR_ACK;
                            mem_wr_en_d   = 1'b1;
                            mem_wr_data_d = sh_q;
                        end
                    end
                end
                DEV_ACK: begin
                    // fetch early so the first read bit is ready at the fall
                    if (scl_rise && rw_q) begin
                        mem_rd_en_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d   = RD;
                            sda_out_d = rd_byte_q[7];
                            sda_en_d  = 1'b1;
                            sh_d      = {rd_byte_q[6:0], 1'b0};
                        end else begin
                            state_d    = ADDR;
                            addr_cnt_d = 2'd0;
                            sda_out_d  = 1'b1;
                            sda_en_d   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_d   = (addr_cnt_q == RA_LAST) ? WR : ADDR;
                        bit_cnt_d = 4'd0;
                        sda_out_d = 1'b1;
                        sda_en_d  = 1'b0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d    = WR;
                        bit_cnt_d  = 4'd0;
                        sda_out_d  = 1'b1;
                        sda_en_d   = 1'b0;
                        mem_addr_d = (mem_addr_q & ~PAGE_MASK)
                                   | ((mem_addr_q + 1'b1) & PAGE_MASK);
                    end
                end
                RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RD_ACK;
                            sda_out_d = 1'b1;
                            sda_en_d  = 1'b0;
                        end else begin
                            sda_out_d = sh_q[7];
                            sh_d      = {sh_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    // address advances after every byte read, ACK or NACK
                    if (scl_rise) begin
                        mem_addr_d = mem_addr_q + 1'b1;
                        if (!sda) begin
                            mem_rd_en_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        state_d   = RD;
                        bit_cnt_d = 4'd0;
                        sda_out_d = rd_byte_q[7];
                        sda_en_d  = 1'b1;
                        sh_d      = {rd_byte_q[6:0], 1'b0};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 4'd0;
            addr_cnt_q    <= 2'd0;
            sh_q          <= 8'h00;
            rw_q          <= 1'b0;
            rd_byte_q     <= 8'h00;
            rd_pend_q     <= 1'b0;
            sda_out_q     <= 1'b1;
            sda_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 8'h00;
            mem_rd_en_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            sh_q          <= sh_d;
            rw_q          <= rw_d;
            rd_byte_q     <= rd_byte_d;
            rd_pend_q     <= rd_pend_d;
            sda_out_q     <= sda_out_d;
            sda_en_q      <= sda_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_rd_en_q   <= mem_rd_en_d;
            busy_q        <= busy_d;
        end
    end

    assign iic_sda_out    = sda_out_q;
    assign iic_sda_out_en = sda_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_wr_data    = mem_wr_data_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_eeprom_iic_tgt.sv
// Directed bench for eeprom_iic_tgt: bus master tasks plus a byte-array memory.
// Memory starts as mem[i] = i[7:0] ^ 8'hA5.
`timescale 1ns/1ps
module tb_eeprom_iic_tgt;
    import eeprom_iic_pkg::*;

    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_out, sda_en;
    logic [11:0] mem_addr;
    logic        mem_wr_en, mem_rd_en, busy;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        init_done = 1'b0;
    logic [7:0]  mem [0:4095];

    logic [11:0] wr_a_q [$];
    logic [7:0]  wr_d_q [$];
    logic [11:0] rd_a_q [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & (sda_en ? sda_out : 1'b1);

    eeprom_iic_tgt dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iic_scl        (scl),
        .iic_sda_in     (sda_bus),
        .iic_sda_out    (sda_out),
        .iic_sda_out_en (sda_en),
        .mem_addr       (mem_addr),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .busy           (busy)
    );

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'hA5;
            init_done <= 1'b1;
        end else begin
            if (mem_rd_en) mem_rd_data <= mem[mem_addr];
            if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_a_q.push_back(mem_addr);
            wr_d_q.push_back(mem_wr_data);
        end
        if (mem_rd_en) rd_a_q.push_back(mem_addr);
    end

    task automatic clear_logs();
        wr_a_q.delete();
        wr_d_q.delete();
        rd_a_q.delete();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1; #(2*Q);
        sda_m = 1'b0; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1; #(2*Q);
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b; #Q;
        scl = 1'b1; #Q;
        s = sda_bus; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(v[i], d);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic b;
        logic [7:0] t;
        t = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, b);
            t[i] = b;
        end
        clk_bit(nack, b);
        v = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({sda_out, sda_en, mem_wr_en, mem_rd_en, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl: got out/en/wr/rd/busy=%b want 10000",
                     {sda_out, sda_en, mem_wr_en, mem_rd_en, busy});
        end
        checks++;
        if (mem_addr !== 12'h000 || mem_wr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h want 000/00",
                     mem_addr, mem_wr_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0]  bytes [5];
        logic [11:0] ea [2];
        logic [7:0]  ed [2];
        bytes = '{8'hA0, 8'h01, 8'h23, 8'h5A, 8'hC3};
        ea = '{12'h123, 12'h124};
        ed = '{8'h5A, 8'hC3};
        clear_logs();
        bus_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL write_ack%0d: got %b want 0", i, ack);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: got %b want 1", busy);
        end
        bus_stop();
        checks++;
        if (wr_a_q.size() != 2) begin
            errors++;
            $display("FAIL write_count: got %0d want 2", wr_a_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_a_q.size() <= i || wr_a_q[i] !== ea[i] || wr_d_q[i] !== ed[i]) begin
                errors++;
                $display("FAIL write_strobe%0d: got %h/%h want %h/%h", i,
                         (wr_a_q.size() > i) ? wr_a_q[i] : 12'hxxx,
                         (wr_d_q.size() > i) ? wr_d_q[i] : 8'hxx, ea[i], ed[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_stop: got %b want 0", busy);
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b0, b1;
        logic [7:0] bytes [3];
        bytes = '{8'hA0, 8'h01, 8'h23};
        clear_logs();
        bus_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL read_addr_ack%0d: got %b want 0", i, ack);
            end
        end
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL read_dev_ack: got %b want 0", ack);
        end
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        checks++;
        if (b0 !== 8'h5A || b1 !== 8'hC3) begin
            errors++;
            $display("FAIL read_data: got %h %h want 5a c3", b0, b1);
        end
        checks++;
        if (sda_en !== 1'b0) begin
            errors++;
            $display("FAIL read_release: got en=%b want 0", sda_en);
        end
        bus_stop();
        checks++;
        if (rd_a_q.size() != 2 || rd_a_q[0] !== 12'h123 || rd_a_q[1] !== 12'h124) begin
            errors++;
            $display("FAIL read_strobes: got n=%0d want 2 at 123,124", rd_a_q.size());
        end
        checks++;
        if (wr_a_q.size() != 0) begin
            errors++;
            $display("FAIL read_no_write: got %0d writes want 0", wr_a_q.size());
        end
    endtask

    task automatic test_dev_nack();
        logic ack;
        clear_logs();
        bus_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL nack_ack: got %b want 1", ack);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nack_busy: got %b want 0", busy);
        end
        send_byte(8'h00, ack);
        bus_stop();
        checks++;
        if (wr_a_q.size() != 0 || rd_a_q.size() != 0) begin
            errors++;
            $display("FAIL nack_strobes: got wr=%0d rd=%0d want 0/0",
                     wr_a_q.size(), rd_a_q.size());
        end
    endtask

    task automatic test_page_wrap();
        logic ack;
        logic [7:0]  bytes [6];
        logic [11:0] ea [3];
        logic [7:0]  ed [3];
        bytes = '{8'hA0, 8'h00, 8'h1E, 8'h11, 8'h22, 8'h33};
        ea = '{12'h01E, 12'h01F, 12'h000};
        ed = '{8'h11, 8'h22, 8'h33};
        clear_logs();
        bus_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL page_ack%0d: got %b want 0", i, ack);
            end
        end
        bus_stop();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_a_q.size() <= i || wr_a_q[i] !== ea[i] || wr_d_q[i] !== ed[i]) begin
                errors++;
                $display("FAIL page_strobe%0d: got %h/%h want %h/%h", i,
                         (wr_a_q.size() > i) ? wr_a_q[i] : 12'hxxx,
                         (wr_d_q.size() > i) ? wr_d_q[i] : 8'hxx, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic ack;
        logic [7:0] b;
        clear_logs();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'hFF, ack);
        bus_stop();
        bus_start();
        send_byte(8'hA1, ack);
        read_byte(1'b1, b);
        bus_stop();
        checks++;
        if (b !== 8'h5A) begin
            errors++;
            $display("FAIL wrap_last_byte: got %h want 5a", b);
        end
        bus_start();
        send_byte(8'hA1, ack);
        read_byte(1'b1, b);
        bus_stop();
        checks++;
        if (rd_a_q.size() != 2 || rd_a_q[1] !== 12'h000) begin
            errors++;
            $display("FAIL wrap_cur_addr: got n=%0d addr=%h want 2/000", rd_a_q.size(),
                     (rd_a_q.size() > 1) ? rd_a_q[1] : 12'hxxx);
        end
        checks++;
        if (b !== 8'h33) begin
            errors++;
            $display("FAIL wrap_cur_byte: got %h want 33", b);
        end
        checks++;
        if (wr_a_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_no_write: got %0d want 0", wr_a_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic [2:0] bits;
        logic b;
        logic [7:0] bytes [4];
        bytes = '{8'hA0, 8'h02, 8'h00, 8'h77};
        clear_logs();
        bus_start();
        send_byte(8'hA1, ack);
        for (int i = 2; i >= 0; i--) begin
            clk_bit(1'b1, b);
            bits[i] = b;
        end
        checks++;
        if (bits !== 3'b101 || sda_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_bits: got %b en=%b want 101 en=1", bits, sda_en);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sda_en !== 1'b0 || dut.state_q !== IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got en=%b state=%0d busy=%b want 0/IDLE/0",
                     sda_en, dut.state_q, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ignore: got ack=%b want 1", ack);
        end
        bus_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL mid_write_ack%0d: got %b want 0", i, ack);
            end
        end
        bus_stop();
        checks++;
        if (wr_a_q.size() != 1 || wr_a_q[0] !== 12'h200 || wr_d_q[0] !== 8'h77) begin
            errors++;
            $display("FAIL mid_write: got n=%0d want 1 write 200/77", wr_a_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_dev_nack();
        test_page_wrap();
        test_addr_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
